// File: rtl/lsu_data_port_pkg.sv
// Shared types and constants for the load/store data port.
// Covers the funct3 size codes, FSM states and response fault causes.
package lsu_data_port_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE_REQ,
        STORE_WAIT,
        RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        MISALIGNED = 2'd1,
        ILLEGAL    = 2'd2,
        TIMEOUT    = 2'd3
    } lsu_cause_t;

endpackage

// File: rtl/lsu_data_port_align.sv
// Combinational sizing for one op.
// Produces byte lanes, replicated store data, extended load data and legality flags.
module lsu_align
    import lsu_data_port_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] store_data,
    output logic [31:0] load_result,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    // The addressed lane is brought down to bit 0 before extension.
    always_comb begin
        shifted     = rdata >> {addr_lo, 3'b000};
        byte_enable = 4'b0000;
        store_data  = 32'h0;
        load_result = 32'h0;
        misaligned  = 1'b0;
        illegal     = 1'b0;
        case (funct3)
            F3_B: begin
                byte_enable = 4'b0001 << addr_lo;
                store_data  = {4{wdata[7:0]}};
                load_result = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                byte_enable = 4'b0011 << addr_lo;
                store_data  = {2{wdata[15:0]}};
                load_result = {{16{shifted[15]}}, shifted[15:0]};
                misaligned  = addr_lo[0];
            end
            F3_W: begin
                byte_enable = 4'b1111;
                store_data  = wdata;
                load_result = shifted;
                misaligned  = |addr_lo;
            end
            F3_BU: begin
                load_result = {24'h0, shifted[7:0]};
                illegal     = is_store;
            end
            F3_HU: begin
                load_result = {16'h0, shifted[15:0]};
                misaligned  = addr_lo[0];
                illegal     = is_store;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_data_port.sv
// Load/store sequencer in front of the unified memory data port.
// Accepts one op at a time, drives the memory side and returns one response per op.
module lsu_data_port
    import lsu_data_port_pkg::*;
#(
    parameter int STORE_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [1:0]  resp_cause,
    output logic [31:0] d_address,
    output logic [31:0] storeData,
    output logic [3:0]  byteEnable,
    output logic        storeValid,
    input  logic [31:0] loadData,
    input  logic        loadDataValid,
    input  logic        storeComplete
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(STORE_TIMEOUT - 1);

    lsu_state_t  state;
    logic        op_store;
    logic [2:0]  op_funct3;
    logic [7:0]  wait_count;

    logic        al_store;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_byte_enable;
    logic [31:0] al_store_data;
    logic [31:0] al_load_result;
    logic        al_misaligned;
    logic        al_illegal;

    // In IDLE the aligner sizes the incoming request; afterwards it works on the held op.
    assign al_store   = (state == IDLE) ? req_store : op_store;
    assign al_funct3  = (state == IDLE) ? req_funct3 : op_funct3;
    assign al_addr_lo = (state == IDLE) ? req_address[1:0] : d_address[1:0];

    lsu_align u_align (
        .is_store    (al_store),
        .funct3      (al_funct3),
        .addr_lo     (al_addr_lo),
        .wdata       (req_wdata),
        .rdata       (loadData),
        .byte_enable (al_byte_enable),
        .store_data  (al_store_data),
        .load_result (al_load_result),
        .misaligned  (al_misaligned),
        .illegal     (al_illegal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_store   <= 1'b0;
            op_funct3  <= 3'b000;
            wait_count <= 8'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_error <= 1'b0;
            resp_cause <= NONE;
            d_address  <= 32'h0;
            storeData  <= 32'h0;
            byteEnable <= 4'b0000;
            storeValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_store  <= req_store;
                        op_funct3 <= req_funct3;
                        req_ready <= 1'b0;
                        // Faulted ops skip the memory entirely.
                        if (al_illegal || al_misaligned) begin
                            resp_valid <= 1'b1;
                            resp_data  <= 32'h0;
                            resp_error <= 1'b1;
                            resp_cause <= al_illegal ? ILLEGAL : MISALIGNED;
                            state      <= RESP;
                        end else if (req_store) begin
                            d_address  <= req_address;
                            storeData  <= al_store_data;
                            byteEnable <= al_byte_enable;
                            storeValid <= 1'b1;
                            wait_count <= 8'h0;
                            state      <= STORE_REQ;
                        end else begin
                            d_address <= req_address;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (loadDataValid) begin
                        resp_valid <= 1'b1;
                        resp_data  <= al_load_result;
                        resp_error <= 1'b0;
                        resp_cause <= NONE;
                        state      <= RESP;
                    end
                end
                STORE_REQ: state <= STORE_WAIT;
                STORE_WAIT: begin
                    if (storeComplete || wait_count == TIMEOUT_LAST) begin
                        storeValid <= 1'b0;
                        byteEnable <= 4'b0000;
                        resp_valid <= 1'b1;
                        resp_data  <= 32'h0;
                        resp_error <= !storeComplete;
                        resp_cause <= storeComplete ? NONE : TIMEOUT;
                        wait_count <= 8'h0;
                        state      <= RESP;
                    end else begin
                        wait_count <= wait_count + 8'h1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_data_port.sv
// Directed bench for lsu_data_port with a small byte-lane memory model.
// The memory writes and pulses storeComplete one cycle after each storeValid rising edge.
module tb_lsu_data_port;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [1:0]  resp_cause;
    logic [31:0] d_address;
    logic [31:0] storeData;
    logic [3:0]  byteEnable;
    logic        storeValid;
    logic [31:0] loadData;
    logic        loadDataValid = 1'b1;
    logic        storeComplete;

    logic [31:0] mem [0:255] = '{8'h40: 32'h80FF1234, default: 32'h0};
    logic        sv_prev = 1'b0;
    logic        mem_pulse = 1'b0;
    logic        stray_pulse = 1'b0;
    logic        mem_respond = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    assign loadData      = mem[d_address[9:2]];
    assign storeComplete = mem_pulse | stray_pulse;

    always @(posedge clock) begin
        sv_prev   <= storeValid;
        mem_pulse <= mem_respond && storeValid && !sv_prev;
        if (storeValid && !sv_prev)
            for (int i = 0; i < 4; i++)
                if (byteEnable[i]) mem[d_address[9:2]][8*i +: 8] <= storeData[8*i +: 8];
    end

    lsu_data_port #(.STORE_TIMEOUT(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_address   (req_address),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_error    (resp_error),
        .resp_cause    (resp_cause),
        .d_address     (d_address),
        .storeData     (storeData),
        .byteEnable    (byteEnable),
        .storeValid    (storeValid),
        .loadData      (loadData),
        .loadDataValid (loadDataValid),
        .storeComplete (storeComplete)
    );

    // Presents one op for a single cycle; returns at the falling edge of the cycle after accept.
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clock);
        req_valid   = 1'b1;
        req_store   = st;
        req_funct3  = f3;
        req_address = a;
        req_wdata   = wd;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        tests_run++;
        if ({req_ready, resp_valid, resp_error, resp_cause} !== 5'b1_0_0_00) begin
            tests_failed++;
            $display("[TB] FAIL reset_handshake: got %b, expected 10000", {req_ready, resp_valid, resp_error, resp_cause});
        end
        tests_run++;
        if ({resp_data, d_address, storeData, byteEnable, storeValid} !== 101'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_datapath: got data=%h addr=%h sd=%h be=%b sv=%b, expected all zero",
                     resp_data, d_address, storeData, byteEnable, storeValid);
        end
        reset = 1'b1;
    endtask

    task automatic test_load();
        loadDataValid = 1'b1;
        send(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        tests_run++;
        if ({resp_valid, req_ready, storeValid} !== 3'b000 || d_address !== 32'h0000_0103) begin
            tests_failed++;
            $display("[TB] FAIL lb_cycle1: got rv/rr/sv=%b addr=%h, expected 000 addr=00000103",
                     {resp_valid, req_ready, storeValid}, d_address);
        end
        @(negedge clock);
        tests_run++;
        if ({resp_valid, resp_error, resp_cause} !== 4'b1000 || resp_data !== 32'hFFFF_FF80) begin
            tests_failed++;
            $display("[TB] FAIL lb_data: got v/e/c=%b data=%h, expected 1000 data=ffffff80",
                     {resp_valid, resp_error, resp_cause}, resp_data);
        end
        take_resp();
        tests_run++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL lb_release: got rv/rr=%b, expected 01", {resp_valid, req_ready});
        end

        send(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        @(negedge clock);
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0080) begin
            tests_failed++;
            $display("[TB] FAIL lbu_data: got v=%b data=%h, expected 1 data=00000080", resp_valid, resp_data);
        end
        take_resp();

        loadDataValid = 1'b0;
        send(1'b0, 3'b001, 32'h0000_0102, 32'h0);
        @(negedge clock);
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lh_wait: got resp_valid=%b, expected 0", resp_valid);
        end
        loadDataValid = 1'b1;
        @(negedge clock);
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_80FF) begin
            tests_failed++;
            $display("[TB] FAIL lh_data: got v=%b data=%h, expected 1 data=ffff80ff", resp_valid, resp_data);
        end
        take_resp();

        send(1'b0, 3'b101, 32'h0000_0100, 32'h0);
        @(negedge clock);
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0000_1234) begin
            tests_failed++;
            $display("[TB] FAIL lhu_data: got v=%b data=%h, expected 1 data=00001234", resp_valid, resp_data);
        end
        take_resp();
    endtask

    task automatic test_store_half();
        send(1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF);
        tests_run++;
        if ({storeValid, byteEnable} !== 5'b1_1100 || storeData !== 32'hBEEF_BEEF || d_address !== 32'h0000_0102) begin
            tests_failed++;
            $display("[TB] FAIL sh_request: got sv/be=%b sd=%h addr=%h, expected 11100 sd=beefbeef addr=00000102",
                     {storeValid, byteEnable}, storeData, d_address);
        end
        @(negedge clock);
        tests_run++;
        if ({storeValid, resp_valid} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL sh_wait: got sv/rv=%b, expected 10", {storeValid, resp_valid});
        end
        @(negedge clock);
        tests_run++;
        if ({resp_valid, resp_error, resp_cause, storeValid, byteEnable} !== 9'b1_0_00_0_0000 || resp_data !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL sh_resp: got v/e/c/sv/be=%b data=%h, expected 100000000 data=0",
                     {resp_valid, resp_error, resp_cause, storeValid, byteEnable}, resp_data);
        end
        take_resp();
        tests_run++;
        if (mem[8'h40] !== 32'hBEEF_1234) begin
            tests_failed++;
            $display("[TB] FAIL sh_memory: got %h, expected beef1234", mem[8'h40]);
        end
    endtask

    task automatic test_errors();
        send(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        tests_run++;
        if ({resp_valid, resp_error, resp_cause, storeValid} !== 5'b1_1_01_0 || d_address !== 32'h0000_0102) begin
            tests_failed++;
            $display("[TB] FAIL lw_misaligned: got v/e/c/sv=%b addr=%h, expected 11010 addr=00000102",
                     {resp_valid, resp_error, resp_cause, storeValid}, d_address);
        end
        take_resp();

        send(1'b0, 3'b011, 32'h0000_0000, 32'h0);
        tests_run++;
        if ({resp_valid, resp_error, resp_cause} !== 4'b1_1_10 || resp_data !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL load_f3_011: got v/e/c=%b data=%h, expected 1110 data=0",
                     {resp_valid, resp_error, resp_cause}, resp_data);
        end
        take_resp();

        send(1'b1, 3'b100, 32'h0000_0000, 32'h0000_0055);
        tests_run++;
        if ({resp_valid, resp_error, resp_cause, storeValid} !== 5'b1_1_10_0) begin
            tests_failed++;
            $display("[TB] FAIL store_f3_100: got v/e/c/sv=%b, expected 11100", {resp_valid, resp_error, resp_cause, storeValid});
        end
        take_resp();

        send(1'b1, 3'b001, 32'h0000_0101, 32'h0000_7777);
        tests_run++;
        if ({resp_valid, resp_error, resp_cause, storeValid, byteEnable} !== 9'b1_1_01_0_0000) begin
            tests_failed++;
            $display("[TB] FAIL sh_misaligned: got v/e/c/sv/be=%b, expected 110100000",
                     {resp_valid, resp_error, resp_cause, storeValid, byteEnable});
        end
        take_resp();
    endtask

    task automatic test_timeout();
        int cycles;
        mem_respond = 1'b0;
        send(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5);
        tests_run++;
        if ({storeValid, byteEnable} !== 5'b1_0010 || storeData !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("[TB] FAIL sb_request: got sv/be=%b sd=%h, expected 10010 sd=a5a5a5a5", {storeValid, byteEnable}, storeData);
        end
        cycles = 0;
        while (!resp_valid && cycles < 40) begin
            @(negedge clock);
            cycles++;
        end
        tests_run++;
        if (cycles != 17) begin
            tests_failed++;
            $display("[TB] FAIL timeout_latency: got %0d cycles, expected 17", cycles);
        end
        tests_run++;
        if ({resp_valid, resp_error, resp_cause, storeValid} !== 5'b1_1_11_0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_resp: got v/e/c/sv=%b, expected 11110", {resp_valid, resp_error, resp_cause, storeValid});
        end
        take_resp();
        mem_respond = 1'b1;
    endtask

    task automatic test_stray_complete();
        @(negedge clock);
        stray_pulse = 1'b1;
        @(negedge clock);
        stray_pulse = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({resp_valid, req_ready, storeValid} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL stray_complete: got rv/rr/sv=%b, expected 010", {resp_valid, req_ready, storeValid});
        end
    endtask

    task automatic test_back_to_back();
        send(1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344);
        tests_run++;
        if ({storeValid, byteEnable} !== 5'b1_1111 || storeData !== 32'h1122_3344) begin
            tests_failed++;
            $display("[TB] FAIL sw1_request: got sv/be=%b sd=%h, expected 11111 sd=11223344", {storeValid, byteEnable}, storeData);
        end
        repeat (2) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({resp_valid, resp_error, resp_cause, storeValid, req_ready} !== 6'b1_0_00_0_0 || resp_data !== 32'h0) begin
                tests_failed++;
                $display("[TB] FAIL sw1_stall%0d: got v/e/c/sv/rr=%b data=%h, expected 100000 data=0",
                         i, {resp_valid, resp_error, resp_cause, storeValid, req_ready}, resp_data);
            end
            if (i < 3) @(negedge clock);
        end
        take_resp();
        tests_run++;
        if ({resp_valid, storeValid, req_ready} !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL sw_gap: got rv/sv/rr=%b, expected 001", {resp_valid, storeValid, req_ready});
        end
        send(1'b1, 3'b010, 32'h0000_0304, 32'h5566_7788);
        tests_run++;
        if (storeValid !== 1'b1 || storeData !== 32'h5566_7788) begin
            tests_failed++;
            $display("[TB] FAIL sw2_request: got sv=%b sd=%h, expected 1 sd=55667788", storeValid, storeData);
        end
        repeat (2) @(negedge clock);
        tests_run++;
        if ({resp_valid, resp_error} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL sw2_resp: got v/e=%b, expected 10", {resp_valid, resp_error});
        end
        take_resp();
        tests_run++;
        if (mem[8'hC0] !== 32'h1122_3344 || mem[8'hC1] !== 32'h5566_7788) begin
            tests_failed++;
            $display("[TB] FAIL sw_memory: got %h %h, expected 11223344 55667788", mem[8'hC0], mem[8'hC1]);
        end
    endtask

    task automatic test_reset_midstore();
        mem_respond = 1'b0;
        send(1'b1, 3'b010, 32'h0000_03F0, 32'hDEAD_BEEF);
        repeat (2) @(negedge clock);
        tests_run++;
        if (storeValid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midstore_active: got storeValid=%b, expected 1", storeValid);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({storeValid, req_ready, resp_valid, byteEnable} !== 7'b0_1_0_0000) begin
            tests_failed++;
            $display("[TB] FAIL midstore_reset: got sv/rr/rv/be=%b, expected 0100000",
                     {storeValid, req_ready, resp_valid, byteEnable});
        end
        @(negedge clock);
        reset = 1'b1;
        mem_respond = 1'b1;
        repeat (2) @(negedge clock);
        tests_run++;
        if ({resp_valid, req_ready, storeValid} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL midstore_no_resp: got rv/rr/sv=%b, expected 010", {resp_valid, req_ready, storeValid});
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_half();
        test_errors();
        test_timeout();
        test_stray_complete();
        test_back_to_back();
        test_reset_midstore();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lsu_data_port.md
Name: lsu_data_port

Overview:
- Load/store sequencer directly upstream of the unified memory's data port.
- Accepts one memory op at a time from the execute stage and sizes it: byte lanes, byte enables, sign/zero-extension, misalignment checks.
- Drives the memory's edge-triggered store request and waits for storeComplete.
- Returns one response per op through a valid/ready handshake.

Parameters:
- STORE_TIMEOUT, 16: max cycles in STORE_WAIT without storeComplete before an error response; 2..255.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  op request valid
- req_ready  output  1  block can accept an op
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32 size/sign code
- req_address  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  response valid
- resp_ready  input  1  consumer takes the response
- resp_data  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  op faulted
- resp_cause  output  2  0 none, 1 misaligned, 2 illegal funct3, 3 store timeout
- d_address  output  32  memory data address
- storeData  output  32  lane-replicated store data
- byteEnable  output  4  store byte lanes
- storeValid  output  1  store request level
- loadData  input  32  memory word, combinational from d_address
- loadDataValid  input  1  loadData usable
- storeComplete  input  1  one-cycle pulse, one cycle after the store edge

Behaviour:
- Reset (reset=0, async) values:
  - State IDLE; req_ready=1.
  - resp_valid=0, resp_data=0, resp_error=0, resp_cause=0.
  - d_address=0, storeData=0, byteEnable=0, storeValid=0.
  - Timeout counter=0.
  - Reset mid-operation drops any in-flight op. No response is produced.
- FSM states: IDLE, LOAD, STORE_REQ, STORE_WAIT, RESP.
- All memory-side and response outputs are registered.
- IDLE:
  - req_ready=1. Accept when req_valid=1 in cycle N; register address, funct3 and data.
  - Legality check at accept:
    - Load funct3 000/001/010/100/101 and store funct3 000/001/010 are legal. Anything else → RESP with cause 2.
    - Half-word with address[0]=1 → cause 1. Word with address[1:0]≠0 → cause 1.
    - Any error goes straight to RESP and never touches the memory outputs.
  - Legal load → LOAD. Legal store → STORE_REQ.
- LOAD (cycle N+1):
  - d_address = registered address.
  - If loadDataValid=1: select lane by address[1:0], sign- or zero-extend to 32 bits, → RESP.
  - Otherwise remain in LOAD.
  - Load response appears at N+2 at the earliest.
- STORE_REQ (cycle N+1):
  - storeValid=1.
  - byteEnable: 4'b0001 << a for SB, 4'b0011 << a for SH, 4'b1111 for SW, where a = address[1:0].
  - storeData: byte replicated ×4 (SB), half-word replicated ×2 (SH), full word (SW).
  - → STORE_WAIT.
- STORE_WAIT:
  - storeValid held at 1; counter increments each cycle.
  - storeComplete=1 → RESP with error 0; storeValid and byteEnable clear on entry to RESP.
  - Counter reaching STORE_TIMEOUT → RESP with cause 3; storeValid clears.
  - Nominal store response appears at N+3.
- RESP:
  - resp_valid=1, held stable until resp_ready=1; then → IDLE and resp_valid drops.
  - req_ready=0 in every state except IDLE.
  - Guarantees storeValid is low for ≥2 cycles between consecutive stores, which the memory's edge detector requires.
- storeComplete arriving outside STORE_WAIT is ignored.
- resp_ready=1 while resp_valid=0 has no effect.

Decomposition:
- StaticPack gains:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Enum lsu_state_t.
  - Enum lsu_cause_t (NONE, MISALIGNED, ILLEGAL, TIMEOUT).
- One sub-module, lsu_align: purely combinational. Given funct3, address[1:0] and data, it produces byteEnable, replicated storeData, extended load result and the misaligned/illegal flags. Keeps the FSM file clean.

Test Plan:
- Reset low mid-STORE_WAIT → storeValid=0, req_ready=1, resp_valid=0 immediately, without waiting for a clock edge.
- LB at 0x00000103, memory word 0x80FF1234 → resp_data=0xFFFFFF80 at N+2, resp_error=0. Same with LBU → 0x00000080.
- SH at 0x00000102, wdata 0x0000BEEF → byteEnable=4'b1100, storeData=0xBEEFBEEF. storeComplete next cycle → resp_valid at N+3, storeValid=0 in RESP.
- LW at 0x00000006 → resp_error=1, cause 1 at N+1, storeValid never asserted. funct3 011 load → cause 2.
- storeComplete held 0 → cause 3 after 16 STORE_WAIT cycles, storeValid drops.
- Two back-to-back SW with resp_ready stalled 3 cycles:
  - resp fields stay stable while stalled.
  - storeValid shows a 0 gap between the two stores.
  - Memory stores both words.
